// File: rtl/game_ctrl_n.sv
// game_ctrl_n: Flappy Bird game-phase FSM with multi-pipe scoring, overflow-safe collision geometry and session high score.
module game_ctrl_n #(
  parameter int NUM_PIPES = 2,
  parameter int COORD_W   = 10,
  parameter int BIRD_R    = 10,
  parameter int PIPE_HW   = 50,
  parameter int GAP_H     = 150,
  parameter int FLOOR_Y   = 1000,
  parameter int SCORE_W   = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic                           Ack,
  input  logic                           Pause,
  input  logic [COORD_W-1:0]             XBird,
  input  logic [COORD_W-1:0]             YBird,
  input  logic [NUM_PIPES*COORD_W-1:0]   XPipes,
  input  logic [NUM_PIPES*COORD_W-1:0]   YPipes,
  output logic                           q_I,
  output logic                           q_EN,
  output logic                           q_P,
  output logic                           q_End,
  output logic [SCORE_W-1:0]             points,
  output logic [SCORE_W-1:0]             high_score,
  output logic                           new_high
);
  localparam int W  = COORD_W + 2;
  localparam int CW = $clog2(NUM_PIPES + 1);
  localparam logic [W-1:0] R  = W'(BIRD_R);
  localparam logic [W-1:0] HW = W'(PIPE_HW);
  localparam logic [W-1:0] GH = W'(GAP_H);
  localparam logic [W-1:0] FL = W'(FLOOR_Y);

  typedef enum logic [3:0] {
    S_INIT  = 4'b0001,
    S_GAME  = 4'b0010,
    S_PAUSE = 4'b0100,
    S_END   = 4'b1000
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_PIPES-1:0]   pass_q, pass_d, behind, hit;
  logic [SCORE_W-1:0]     points_q, points_d, high_q, high_d, scored;
  logic                   new_high_q, new_high_d, crash;
  logic [W-1:0]           xb, yb;
  logic [CW-1:0]          cross_n;
  logic [SCORE_W:0]       sum;

  assign xb = W'(XBird);
  assign yb = W'(YBird);

  // Every term is widened by two bits and compared additively, so nothing can wrap near zero.
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    logic [W-1:0] xp, yp;
    assign xp        = W'(XPipes[i*COORD_W +: COORD_W]);
    assign yp        = W'(YPipes[i*COORD_W +: COORD_W]);
    assign behind[i] = xb >= xp;
    assign hit[i]    = (xb + R + HW > xp) && (xb < xp + HW + R) &&
                       ((yb < yp + R) || (yb + R > yp + GH));
  end

  assign crash = (|hit) || (yb > FL);

  always_comb begin
    cross_n = '0;
    for (int i = 0; i < NUM_PIPES; i++)
      cross_n = cross_n + CW'(~pass_q[i] & behind[i]);
  end

  assign sum    = {1'b0, points_q} + (SCORE_W+1)'(cross_n);
  assign scored = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    points_d   = points_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    case (state_q)
      S_INIT: begin
        points_d   = '0;
        new_high_d = 1'b0;
        if (Start) begin
          state_d = S_GAME;
          pass_d  = behind;
        end
      end
      S_GAME: begin
        if (crash) begin
          state_d  = S_END;
          pass_d   = behind;
          points_d = scored;
          if (scored > high_q) begin
            high_d     = scored;
            new_high_d = 1'b1;
          end
        end else if (Pause) begin
          state_d = S_PAUSE;
        end else begin
          pass_d   = behind;
          points_d = scored;
        end
      end
      S_PAUSE: state_d = Pause ? S_PAUSE : S_GAME;
      S_END: begin
        if (Ack) begin
          state_d    = S_INIT;
          new_high_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_INIT;
      pass_q     <= '1;
      points_q   <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      points_q   <= points_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  assign q_I        = state_q[0];
  assign q_EN       = state_q[1];
  assign q_P        = state_q[2];
  assign q_End      = state_q[3];
  assign points     = points_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;
endmodule

// File: tb/tb_game_ctrl_n.sv
// tb_game_ctrl_n: table-driven scoreboard bench for game_ctrl_n with hand-written sweep and pause sequences.
module tb_game_ctrl_n;
  localparam logic [3:0] I = 4'b0001, EN = 4'b0010, P = 4'b0100, E = 4'b1000;

  typedef struct {
    logic rst_n, start, ack, pause;
    logic [9:0] xb, yb, xp0, xp1;
    logic [3:0] st;
    logic [15:0] pts, hs;
    logic nh;
  } vec_t;

  logic Clk = 1'b0, Reset, Start, Ack, Pause;
  logic [9:0] XBird, YBird;
  logic [19:0] XPipes, YPipes;
  logic q_I, q_EN, q_P, q_End, new_high;
  logic [15:0] points, high_score;
  logic [36:0] exp_q[$];
  int n_run = 0, n_fail = 0, idx = 0;

  game_ctrl_n dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Pause(Pause),
    .XBird(XBird), .YBird(YBird), .XPipes(XPipes), .YPipes(YPipes),
    .q_I(q_I), .q_EN(q_EN), .q_P(q_P), .q_End(q_End),
    .points(points), .high_score(high_score), .new_high(new_high)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t v(input logic r, s, a, p, input int xb, yb, xp0, xp1,
                             input logic [3:0] st, input int pts, hs, input logic nh);
    vec_t t;
    t.rst_n = r; t.start = s; t.ack = a; t.pause = p;
    t.xb = 10'(xb); t.yb = 10'(yb); t.xp0 = 10'(xp0); t.xp1 = 10'(xp1);
    t.st = st; t.pts = 16'(pts); t.hs = 16'(hs); t.nh = nh;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    logic [36:0] got, exp;
    Reset = t.rst_n; Start = t.start; Ack = t.ack; Pause = t.pause;
    XBird = t.xb; YBird = t.yb; XPipes = {t.xp1, t.xp0};
    exp_q.push_back({t.st, t.pts, t.hs, t.nh});
    @(posedge Clk);
    #1;
    got = {q_End, q_P, q_EN, q_I, points, high_score, new_high};
    exp = exp_q.pop_front();
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec%0d: got st=%b pts=%0d hs=%0d nh=%b, expected st=%b pts=%0d hs=%0d nh=%b",
               idx, got[36:33], got[32:17], got[16:1], got[0], exp[36:33], exp[32:17], exp[16:1], exp[0]);
    end
    idx++;
  endtask

  initial begin
    vec_t tbl[$];
    YPipes = {10'd200, 10'd200};
    // reset, start, score sweep of pipe 0
    apply(v(0,0,0,0, 100,250,300,600, I,0,0,0));
    apply(v(1,0,0,0, 100,250,300,600, I,0,0,0));
    apply(v(1,1,0,0, 100,250,300,600, EN,0,0,0));
    for (int x = 300; x >= 99; x--)
      apply(v(1,0,0,0, 100,250,x,600, EN,(x <= 100) ? 1 : 0,0,0));
    // game 1: double crossing, near-miss, collision, ack
    tbl.push_back(v(1,0,0,0, 100,250,99,600,  EN,1,0,0));
    tbl.push_back(v(1,0,0,0, 100,250,99,600,  EN,1,0,0));
    tbl.push_back(v(1,0,0,0, 100,250,101,101, EN,1,0,0));
    tbl.push_back(v(1,0,0,0, 100,250,100,100, EN,3,0,0));
    tbl.push_back(v(1,0,0,0, 100,215,150,600, EN,3,0,0));
    tbl.push_back(v(1,0,0,0, 100,205,150,600, E,3,3,1));
    tbl.push_back(v(1,0,0,0, 100,250,300,600, E,3,3,1));
    tbl.push_back(v(1,0,1,0, 100,250,300,600, I,3,3,0));
    tbl.push_back(v(1,0,0,0, 100,250,300,600, I,0,3,0));
    // game 2: two points, then pause
    tbl.push_back(v(1,1,0,0, 100,250,300,600, EN,0,3,0));
    tbl.push_back(v(1,0,0,0, 100,250,100,600, EN,1,3,0));
    tbl.push_back(v(1,0,0,0, 100,250,101,101, EN,1,3,0));
    tbl.push_back(v(1,0,0,0, 100,250,101,100, EN,2,3,0));
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
    for (int k = 0; k < 20; k++)
      apply(v(1,0,0,1, 100,250,(k < 19) ? 101 - k : 101,100 - k, P,2,3,0));
    // resume, floor boundary, fall, ack
    tbl.push_back(v(1,0,0,0, 100,250,101,81,   EN,2,3,0));
    tbl.push_back(v(1,0,0,0, 100,250,101,81,   EN,2,3,0));
    tbl.push_back(v(1,0,0,0, 100,1000,300,600, EN,2,3,0));
    tbl.push_back(v(1,0,0,0, 100,1001,300,600, E,2,3,0));
    tbl.push_back(v(1,0,1,0, 100,250,300,600,  I,2,3,0));
    tbl.push_back(v(1,0,0,0, 100,250,300,600,  I,0,3,0));
    // game 3: low-X collision with simultaneous crossing, then held Start restarts
    tbl.push_back(v(1,1,0,0, 5,250,300,600, EN,0,3,0));
    tbl.push_back(v(1,0,0,0, 5,150,3,600,   E,1,3,0));
    tbl.push_back(v(1,1,1,0, 5,150,3,600,   I,1,3,0));
    tbl.push_back(v(1,1,1,0, 100,250,300,600, EN,0,3,0));
    // game 4: score, mid-game reset
    tbl.push_back(v(1,0,0,0, 100,250,100,600, EN,1,3,0));
    tbl.push_back(v(0,0,0,0, 100,250,100,600, I,0,0,0));
    tbl.push_back(v(1,0,0,0, 100,250,100,600, I,0,0,0));
    // pipe already behind at start never scores
    tbl.push_back(v(1,1,0,0, 100,250,50,600, EN,0,0,0));
    tbl.push_back(v(1,0,0,0, 100,250,50,600, EN,0,0,0));
    tbl.push_back(v(1,0,0,0, 100,250,45,600, EN,0,0,0));
    foreach (tbl[i]) apply(tbl[i]);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
